// File: rtl/serial_adder.sv
// serial_adder: clocked bit-serial adder with four-phase req/fin handshake.
// Operands are latched at acceptance and summed LSB-first, one bit per clock.
// The run stops early once every remaining operand bit and the carry are
// zero; unprocessed sum bits are known to be zero and stay cleared.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             fin,
  output logic             busy,
  output logic [WIDTH-1:0] s,
  output logic             cout
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic             r_carry;
  logic [IW-1:0]    r_i;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  logic             w_sum_bit;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] w_ra_sh;
  logic [WIDTH-1:0] w_rb_sh;
  logic             w_last_bit;
  logic             w_rest_zero;
  logic             w_run_end;
  logic             w_accept;

  // Full-adder cell on the current LSBs plus termination conditions
  always_comb begin
    w_sum_bit   = r_ra[0] ^ r_rb[0] ^ r_carry;
    w_carry_nxt = (r_ra[0] & r_rb[0]) | (r_ra[0] & r_carry) | (r_rb[0] & r_carry);
    w_ra_sh     = {1'b0, r_ra[WIDTH-1:1]};
    w_rb_sh     = {1'b0, r_rb[WIDTH-1:1]};
    w_last_bit  = (r_i == IW'(WIDTH - 1));
    // Nothing left that could set a higher sum bit: stop early
    w_rest_zero = (w_ra_sh == '0) && (w_rb_sh == '0) && !w_carry_nxt;
    w_run_end   = (r_state == ST_RUN) && (w_rest_zero || w_last_bit);
    w_accept    = (r_state == ST_IDLE) && req;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: req is only looked at in IDLE and DONE
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (req)       w_state_nxt = ST_RUN;
      ST_RUN:  if (w_run_end) w_state_nxt = ST_DONE;
      ST_DONE: if (!req)      w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the registered state only (no req-to-fin path)
  always_comb begin
    fin  = 1'b0;
    busy = 1'b0;
    unique case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: fin  = 1'b1;
      default: ;
    endcase
  end

  // Operand shift registers, carry and bit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ra    <= '0;
      r_rb    <= '0;
      r_carry <= 1'b0;
      r_i     <= '0;
    end else if (w_accept) begin
      r_ra    <= a;
      r_rb    <= b;
      r_carry <= 1'b0;
      r_i     <= '0;
    end else if (r_state == ST_RUN) begin
      r_ra    <= w_ra_sh;
      r_rb    <= w_rb_sh;
      r_carry <= w_carry_nxt;
      r_i     <= r_i + IW'(1);
    end
  end

  // Sum and carry-out: cleared on accept, built during RUN, held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else if (w_accept) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else if (r_state == ST_RUN) begin
      r_s[r_i] <= w_sum_bit;
      // Early exit guarantees a zero carry, so only a full run can carry out
      if (w_run_end) begin
        r_cout <= w_last_bit ? w_carry_nxt : 1'b0;
      end
    end
  end

  assign s    = r_s;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed and randomised checks of serial_adder against
// an arithmetic reference model ({cout,s} = a+b, cycle count = k).
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         req;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         fin;
  logic         busy;
  logic [W-1:0] s;
  logic         cout;

  int checks;
  int failures;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (req),
    .a    (a),
    .b    (b),
    .fin  (fin),
    .busy (busy),
    .s    (s),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bits processed: one past the highest position where either operand or
  // the incoming carry is set, at least 1, at most W.
  function automatic int calc_k(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0]   sum;
    logic [W:0]   cin;
    logic [W-1:0] need;
    int           k;
    sum  = {1'b0, x} + {1'b0, y};
    cin  = sum ^ {1'b0, x} ^ {1'b0, y};
    need = x | y | cin[W-1:0];
    k    = 1;
    for (int p = 0; p < W; p++) if (need[p]) k = p + 1;
    return k;
  endfunction

  // Runs one addition; drop_early releases req right after acceptance.
  // hold_extra keeps req high for that many cycles in DONE.
  task automatic do_add(input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit drop_early, input int hold_extra, input string tag);
    logic [W:0] exp_sum;
    int         k;
    int         cnt;
    logic [W-1:0] s_done;
    exp_sum = {1'b0, x} + {1'b0, y};
    k       = calc_k(x, y);
    a   = x;
    b   = y;
    req = 1'b1;
    @(posedge clk); #1;                 // E0
    a = W'($urandom);                   // operands must be latched
    b = W'($urandom);
    if (drop_early) req = 1'b0;
    cnt = 0;
    check({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
    while (!fin && cnt < W + 3) begin
      @(posedge clk); #1;
      cnt++;
    end
    check({tag, "_cycles"}, cnt, k);
    check({tag, "_s"}, {24'd0, s}, {24'd0, exp_sum[W-1:0]});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_sum[W]});
    check({tag, "_busy_done"}, {31'd0, busy}, 32'd0);
    s_done = s;
    for (int h = 0; h < hold_extra; h++) begin
      @(posedge clk); #1;
      check({tag, "_hold_fin"}, {31'd0, fin}, 32'd1);
      check({tag, "_hold_s"}, {24'd0, s}, {24'd0, s_done});
    end
    req = 1'b0;
    @(posedge clk); #1;
    check({tag, "_fin_low"}, {31'd0, fin}, 32'd0);
    check({tag, "_s_kept"}, {24'd0, s}, {24'd0, exp_sum[W-1:0]});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    req   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_fin", {31'd0, fin}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_s", {24'd0, s}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_add(8'd3, 8'd5, 1'b0, 0, "a3b5");
    do_add(8'd0, 8'd0, 1'b0, 0, "zero");
    do_add(8'hFF, 8'h01, 1'b0, 0, "ff01");
    do_add(8'h80, 8'h80, 1'b0, 0, "8080");
    do_add(8'h2C, 8'h17, 1'b0, 5, "hold");
    do_add(8'd1, 8'd1, 1'b0, 0, "a1b1");

    // Asynchronous reset in the middle of a long run
    a   = 8'hFF;
    b   = 8'h01;
    req = 1'b1;
    @(posedge clk); #1;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_fin", {31'd0, fin}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_s", {24'd0, s}, 32'd0);
    check("arst_cout", {31'd0, cout}, 32'd0);
    req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_add(8'h9A, 8'h7B, 1'b0, 0, "post_rst");

    for (int n = 0; n < 1000; n++) begin
      do_add(W'($urandom), W'($urandom), bit'($urandom_range(0, 1)), 0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
